// File: rtl/ee354_gcd_arbiter_pkg.sv
// Shared definitions for the GCD core arbiter: default sizes, the one-hot
// controller state encoding and a state legality helper.
package ee354_gcd_arbiter_pkg;

    localparam int N_REQ_DEF  = 4;
    localparam int DW_DEF     = 8;
    localparam int WD_MAX_DEF = 1023;

    // One-hot controller states; any other code is treated as illegal.
    typedef enum logic [5:0] {
        ST_IDLE  = 6'b000001,
        ST_LOAD  = 6'b000010,
        ST_WAIT  = 6'b000100,
        ST_ACK   = 6'b001000,
        ST_RESP  = 6'b010000,
        ST_ABORT = 6'b100000
    } state_t;

    function automatic logic state_is_legal(input state_t s);
        case (s)
            ST_IDLE, ST_LOAD, ST_WAIT, ST_ACK, ST_RESP, ST_ABORT: return 1'b1;
            default:                                              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ee354_gcd_arbiter_if.sv
// Requester-side bus of the GCD arbiter: level requests with flattened
// operands, one-hot grant/valid and the shared result.
interface ee354_gcd_arbiter_if
    import ee354_gcd_arbiter_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int DW    = DW_DEF
) ();

    logic [N_REQ-1:0]    Req;
    logic [N_REQ*DW-1:0] Req_A;
    logic [N_REQ*DW-1:0] Req_B;
    logic [N_REQ-1:0]    Grant;
    logic [N_REQ-1:0]    Rsp_Valid;
    logic [N_REQ-1:0]    Rsp_Ack;
    logic [DW-1:0]       Rsp_Gcd;
    logic                Rsp_Err;

    // Requester side drives requests/acks and observes the response.
    modport master (
        output Req, Req_A, Req_B, Rsp_Ack,
        input  Grant, Rsp_Valid, Rsp_Gcd, Rsp_Err
    );

    // Arbiter side.
    modport slave (
        input  Req, Req_A, Req_B, Rsp_Ack,
        output Grant, Rsp_Valid, Rsp_Gcd, Rsp_Err
    );

endinterface

// File: rtl/ee354_gcd_arbiter_rr_pick.sv
// Combinational round-robin picker: searches the request vector upward from
// the priority pointer, wrapping around, and returns the first hit both as a
// one-hot vector and as an index.
module ee354_gcd_arbiter_rr_pick
    import ee354_gcd_arbiter_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int IW    = $clog2(N_REQ_DEF)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] win,
    output logic [IW-1:0]    win_idx,
    output logic             any
);

    logic [IW-1:0] idx;

    // Walk from ptr with wrap; the first requester found wins.
    always_comb begin
        win     = '0;
        win_idx = '0;
        any     = 1'b0;
        idx     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = IW'((int'(ptr) + k) % N_REQ);
            if (!any && req[idx]) begin
                any      = 1'b1;
                win_idx  = idx;
                win[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ee354_gcd_arbiter.sv
// Shares a single ee354 GCD core among N_REQ requesters. A round-robin winner
// has its operands latched, the core is sequenced through Start/Ack, and the
// result is returned to the winner. Zero operands are answered without the
// core (it never terminates on zero) and a SCEN-gated watchdog resets a core
// that stops making progress.
module ee354_gcd_arbiter
    import ee354_gcd_arbiter_pkg::*;
#(
    parameter int N_REQ  = N_REQ_DEF,
    parameter int DW     = DW_DEF,
    parameter int WD_MAX = WD_MAX_DEF
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 SCEN,
    ee354_gcd_arbiter_if.slave   bus,
    output logic                 Core_Reset,
    output logic                 Core_Start,
    output logic                 Core_Ack,
    output logic [DW-1:0]        Core_Ain,
    output logic [DW-1:0]        Core_Bin,
    input  logic                 Core_Done,
    input  logic [DW-1:0]        Core_Gcd
);

    localparam int IW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int WDW = $clog2(WD_MAX + 1);

    state_t           state, state_nxt;
    logic [IW-1:0]    ptr, ptr_nxt;
    logic [IW-1:0]    owner, owner_nxt;
    logic [N_REQ-1:0] grant, grant_nxt;
    logic [N_REQ-1:0] rsp_valid, rsp_valid_nxt;
    logic [DW-1:0]    rsp_gcd, rsp_gcd_nxt;
    logic             rsp_err, rsp_err_nxt;
    logic             core_start, core_start_nxt;
    logic             core_ack, core_ack_nxt;
    logic [DW-1:0]    ain, ain_nxt;
    logic [DW-1:0]    bin, bin_nxt;
    logic [WDW-1:0]   wd, wd_nxt;

    logic [N_REQ-1:0] win;
    logic [IW-1:0]    win_idx;
    logic             win_any;
    logic [DW-1:0]    sel_a;
    logic [DW-1:0]    sel_b;

    // gcd(0,b)=b and gcd(0,0)=0, so a zero operand is resolved by OR.
    function automatic logic has_zero(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return (a == '0) || (b == '0);
    endfunction

    function automatic logic [DW-1:0] zero_gcd(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return a | b;
    endfunction

    ee354_gcd_arbiter_rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_pick (
        .req     (bus.Req),
        .ptr     (ptr),
        .win     (win),
        .win_idx (win_idx),
        .any     (win_any)
    );

    assign sel_a = bus.Req_A[win_idx*DW +: DW];
    assign sel_b = bus.Req_B[win_idx*DW +: DW];

    // Next-state and next-output logic; Start/Ack default low so each is a
    // single-cycle pulse in LOAD/ACK.
    always_comb begin
        state_nxt      = state;
        ptr_nxt        = ptr;
        owner_nxt      = owner;
        grant_nxt      = grant;
        rsp_valid_nxt  = rsp_valid;
        rsp_gcd_nxt    = rsp_gcd;
        rsp_err_nxt    = rsp_err;
        core_start_nxt = 1'b0;
        core_ack_nxt   = 1'b0;
        ain_nxt        = ain;
        bin_nxt        = bin;
        wd_nxt         = wd;

        case (state)
            ST_IDLE: begin
                if (win_any) begin
                    owner_nxt = win_idx;
                    grant_nxt = win;
                    ain_nxt   = sel_a;
                    bin_nxt   = sel_b;
                    if (has_zero(sel_a, sel_b)) begin
                        rsp_gcd_nxt   = zero_gcd(sel_a, sel_b);
                        rsp_err_nxt   = 1'b0;
                        rsp_valid_nxt = win;
                        state_nxt     = ST_RESP;
                    end else begin
                        core_start_nxt = 1'b1;
                        state_nxt      = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                wd_nxt    = '0;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (Core_Done) begin
                    rsp_gcd_nxt  = Core_Gcd;
                    core_ack_nxt = 1'b1;
                    state_nxt    = ST_ACK;
                end else if (SCEN) begin
                    if (wd == WDW'(WD_MAX)) begin
                        state_nxt = ST_ABORT;
                    end else begin
                        wd_nxt = wd + 1'b1;
                    end
                end
            end
            ST_ACK: begin
                rsp_err_nxt   = 1'b0;
                rsp_valid_nxt = grant;
                state_nxt     = ST_RESP;
            end
            ST_ABORT: begin
                rsp_gcd_nxt   = '0;
                rsp_err_nxt   = 1'b1;
                rsp_valid_nxt = grant;
                state_nxt     = ST_RESP;
            end
            ST_RESP: begin
                // Only the owner's acknowledge retires the transaction.
                if (bus.Rsp_Ack[owner]) begin
                    rsp_valid_nxt = '0;
                    grant_nxt     = '0;
                    rsp_err_nxt   = 1'b0;
                    ptr_nxt       = (owner == IW'(N_REQ - 1)) ? '0 : owner + 1'b1;
                    state_nxt     = ST_IDLE;
                end
            end
            default: begin
                grant_nxt     = '0;
                rsp_valid_nxt = '0;
                rsp_err_nxt   = 1'b0;
                state_nxt     = ST_IDLE;
            end
        endcase
    end

    // State and registered-output update with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state      <= ST_IDLE;
            ptr        <= '0;
            owner      <= '0;
            grant      <= '0;
            rsp_valid  <= '0;
            rsp_gcd    <= '0;
            rsp_err    <= 1'b0;
            core_start <= 1'b0;
            core_ack   <= 1'b0;
            ain        <= '0;
            bin        <= '0;
            wd         <= '0;
        end else begin
            state      <= state_nxt;
            ptr        <= ptr_nxt;
            owner      <= owner_nxt;
            grant      <= grant_nxt;
            rsp_valid  <= rsp_valid_nxt;
            rsp_gcd    <= rsp_gcd_nxt;
            rsp_err    <= rsp_err_nxt;
            core_start <= core_start_nxt;
            core_ack   <= core_ack_nxt;
            ain        <= ain_nxt;
            bin        <= bin_nxt;
            wd         <= wd_nxt;
        end
    end

    // The core is held in reset during our reset, for the abort cycle, and
    // for the recovery cycle after an illegal state code.
    assign Core_Reset = !Reset_n || (state == ST_ABORT) || !state_is_legal(state);

    assign bus.Grant     = grant;
    assign bus.Rsp_Valid = rsp_valid;
    assign bus.Rsp_Gcd   = rsp_gcd;
    assign bus.Rsp_Err   = rsp_err;
    assign Core_Start    = core_start;
    assign Core_Ack      = core_ack;
    assign Core_Ain      = ain;
    assign Core_Bin      = bin;

endmodule

// File: tb/tb_ee354_gcd_arbiter.sv
// Bench for ee354_gcd_arbiter with a behavioural subtract-loop GCD core.
module tb_ee354_gcd_arbiter;

    localparam logic [1:0] C_I    = 2'd0;
    localparam logic [1:0] C_SUB  = 2'd1;
    localparam logic [1:0] C_DONE = 2'd2;

    typedef struct {
        int         idx;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] g;
        int         starts;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       scen;
    logic       core_reset, core_start, core_ack, core_done;
    logic [7:0] core_ain, core_bin, core_gcd;
    bit         stuck;

    int checks = 0;
    int passed = 0;

    // core model state
    logic [1:0] c_st = C_I;
    logic [7:0] c_a = 8'd0;
    logic [7:0] c_b = 8'd0;

    // monitor state
    int cyc = 0;
    int start_cnt = 0, start_cyc = 0;
    int rst_cnt = 0, rst_cyc = 0;
    int done_cyc = 0, valid_cyc = 0;
    bit prev_done = 1'b0, prev_valid = 1'b0;

    vec_t vecs[8];

    ee354_gcd_arbiter_if #(.N_REQ(4), .DW(8)) bus ();

    ee354_gcd_arbiter #(.N_REQ(4), .DW(8), .WD_MAX(15)) dut (
        .Clk        (clk),
        .Reset_n    (reset_n),
        .SCEN       (scen),
        .bus        (bus),
        .Core_Reset (core_reset),
        .Core_Start (core_start),
        .Core_Ack   (core_ack),
        .Core_Ain   (core_ain),
        .Core_Bin   (core_bin),
        .Core_Done  (core_done),
        .Core_Gcd   (core_gcd)
    );

    always #5 clk = ~clk;

    // Behavioural GCD core: I -> SUB on Start, subtract while SCEN, DONE until Ack.
    always @(posedge clk) begin
        if (core_reset) begin
            c_st <= C_I;
            c_a  <= 8'd0;
            c_b  <= 8'd0;
        end else begin
            case (c_st)
                C_I: if (core_start) begin
                    c_a  <= core_ain;
                    c_b  <= core_bin;
                    c_st <= C_SUB;
                end
                C_SUB: if (scen) begin
                    if (c_a == c_b)     c_st <= C_DONE;
                    else if (c_a > c_b) c_a  <= c_a - c_b;
                    else                c_b  <= c_b - c_a;
                end
                C_DONE: if (core_ack) c_st <= C_I;
                default: c_st <= C_I;
            endcase
        end
    end
    assign core_done = (c_st == C_DONE) && !stuck;
    assign core_gcd  = c_a;

    // Event monitor sampled on the falling edge.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (core_start) begin
            start_cnt <= start_cnt + 1;
            start_cyc <= cyc;
        end
        if (core_reset && reset_n) begin
            rst_cnt <= rst_cnt + 1;
            rst_cyc <= cyc;
        end
        prev_done  <= core_done;
        prev_valid <= |bus.Rsp_Valid;
        if (core_done && !prev_done) done_cyc <= cyc;
        if ((|bus.Rsp_Valid) && !prev_valid) valid_cyc <= cyc;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag);
        bit got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (|bus.Rsp_Valid) begin
                got = 1'b1;
                break;
            end
        end
        check({tag, " valid_seen"}, 32'(got), 32'd1);
    endtask

    task automatic drive(input int idx, input logic [7:0] a, input logic [7:0] b);
        bus.Req_A[idx*8 +: 8] = a;
        bus.Req_B[idx*8 +: 8] = b;
        bus.Req               = 4'(1 << idx);
    endtask

    task automatic ack_owner(input logic [3:0] oh, input string tag);
        bus.Rsp_Ack = oh;
        tick();
        bus.Rsp_Ack = 4'b0;
        bus.Req     = 4'b0;
        check({tag, " valid_clr"}, 32'(bus.Rsp_Valid), 32'd0);
        check({tag, " grant_clr"}, 32'(bus.Grant), 32'd0);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        logic [3:0] oh;
        int s0, drive_cyc;
        oh = 4'(1 << v.idx);
        s0 = start_cnt;
        drive(v.idx, v.a, v.b);
        drive_cyc = cyc;
        wait_valid(tag);
        check({tag, " valid"}, 32'(bus.Rsp_Valid), 32'(oh));
        check({tag, " grant"}, 32'(bus.Grant), 32'(oh));
        check({tag, " gcd"}, 32'(bus.Rsp_Gcd), 32'(v.g));
        check({tag, " err"}, 32'(bus.Rsp_Err), 32'd0);
        check({tag, " starts"}, 32'(start_cnt - s0), 32'(v.starts));
        if (v.starts != 0) begin
            check({tag, " idle_to_load"}, 32'(start_cyc), 32'(drive_cyc));
            check({tag, " done_to_valid"}, 32'(valid_cyc - done_cyc), 32'd2);
        end else begin
            check({tag, " bypass_latency"}, 32'(valid_cyc), 32'(drive_cyc));
        end
        ack_owner(oh, tag);
        check({tag, " core_idle"}, 32'(c_st), 32'(C_I));
    endtask

    initial begin
        int s0, r0;
        logic [3:0] exp_oh;

        vecs[0] = '{0, 8'd36,  8'd24, 8'd12, 1};
        vecs[1] = '{2, 8'd0,   8'd9,  8'd9,  0};
        vecs[2] = '{2, 8'd0,   8'd0,  8'd0,  0};
        vecs[3] = '{1, 8'd48,  8'd18, 8'd6,  1};
        vecs[4] = '{3, 8'd7,   8'd0,  8'd7,  0};
        vecs[5] = '{1, 8'd255, 8'd85, 8'd85, 1};
        vecs[6] = '{3, 8'd17,  8'd5,  8'd1,  1};
        vecs[7] = '{0, 8'd9,   8'd9,  8'd9,  1};

        reset_n     = 1'b0;
        scen        = 1'b1;
        stuck       = 1'b0;
        bus.Req     = 4'b0;
        bus.Req_A   = 32'd0;
        bus.Req_B   = 32'd0;
        bus.Rsp_Ack = 4'b0;

        // Reset state
        tick();
        tick();
        check("rst grant", 32'(bus.Grant), 32'd0);
        check("rst valid", 32'(bus.Rsp_Valid), 32'd0);
        check("rst gcd", 32'(bus.Rsp_Gcd), 32'd0);
        check("rst err", 32'(bus.Rsp_Err), 32'd0);
        check("rst start", 32'(core_start), 32'd0);
        check("rst ack", 32'(core_ack), 32'd0);
        check("rst ain", 32'(core_ain), 32'd0);
        check("rst core_reset", 32'(core_reset), 32'd1);
        reset_n = 1'b1;
        tick();
        check("run core_reset", 32'(core_reset), 32'd0);

        // Round-robin with all four requesting (15,10)
        bus.Req_A = {4{8'd15}};
        bus.Req_B = {4{8'd10}};
        bus.Req   = 4'hF;
        for (int t = 0; t < 5; t++) begin
            exp_oh = 4'(1 << (t % 4));
            wait_valid("rr");
            check("rr grant", 32'(bus.Grant), 32'(exp_oh));
            check("rr valid", 32'(bus.Rsp_Valid), 32'(exp_oh));
            check("rr gcd", 32'(bus.Rsp_Gcd), 32'd5);
            bus.Rsp_Ack = exp_oh;
            tick();
            bus.Rsp_Ack = 4'b0;
        end
        bus.Req = 4'b0;
        tick();
        tick();

        // Directed single-requester vectors
        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
            tick();
        end

        // Watchdog abort on a hung core
        stuck = 1'b1;
        s0 = start_cnt;
        r0 = rst_cnt;
        drive(1, 8'd20, 8'd8);
        wait_valid("wd");
        check("wd valid", 32'(bus.Rsp_Valid), 32'b0010);
        check("wd gcd", 32'(bus.Rsp_Gcd), 32'd0);
        check("wd err", 32'(bus.Rsp_Err), 32'd1);
        check("wd starts", 32'(start_cnt - s0), 32'd1);
        check("wd core_reset_pulses", 32'(rst_cnt - r0), 32'd1);
        check("wd abort_time", 32'(rst_cyc - start_cyc), 32'd17);
        check("wd core_idle", 32'(c_st), 32'(C_I));
        ack_owner(4'b0010, "wd");
        check("wd err_clr", 32'(bus.Rsp_Err), 32'd0);
        stuck = 1'b0;
        tick();

        // Operands changed and Req dropped while granted; non-owner ack ignored
        drive(1, 8'd15, 8'd10);
        tick();
        tick();
        bus.Req_A[15:8] = 8'd99;
        bus.Req         = 4'b0;
        wait_valid("hold");
        check("hold gcd", 32'(bus.Rsp_Gcd), 32'd5);
        bus.Rsp_Ack = 4'b0001;
        tick();
        check("hold foreign_ack", 32'(bus.Rsp_Valid), 32'b0010);
        ack_owner(4'b0010, "hold");
        tick();

        // Reset during WAIT abandons the transaction
        scen = 1'b0;
        drive(0, 8'd36, 8'd24);
        tick();
        tick();
        tick();
        reset_n = 1'b0;
        tick();
        check("midrst grant", 32'(bus.Grant), 32'd0);
        check("midrst valid", 32'(bus.Rsp_Valid), 32'd0);
        check("midrst ain", 32'(core_ain), 32'd0);
        check("midrst bin", 32'(core_bin), 32'd0);
        check("midrst start", 32'(core_start), 32'd0);
        check("midrst core_reset", 32'(core_reset), 32'd1);
        bus.Req = 4'b0;
        tick();
        reset_n = 1'b1;
        scen    = 1'b1;
        tick();
        tick();
        check("postrst valid", 32'(bus.Rsp_Valid), 32'd0);
        run_vec('{3, 8'd8, 8'd12, 8'd4, 1}, "postrst");
        tick();

        // Long SCEN=0 stall in WAIT must not trip the watchdog
        scen = 1'b0;
        r0 = rst_cnt;
        drive(2, 8'd48, 8'd18);
        repeat (2000) tick();
        check("stall valid", 32'(bus.Rsp_Valid), 32'd0);
        check("stall grant", 32'(bus.Grant), 32'b0100);
        check("stall no_abort", 32'(rst_cnt - r0), 32'd0);
        scen = 1'b1;
        wait_valid("stall");
        check("stall gcd", 32'(bus.Rsp_Gcd), 32'd6);
        check("stall err", 32'(bus.Rsp_Err), 32'd0);
        ack_owner(4'b0100, "stall");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
